// File: rtl/network_sequencer.sv
// network_sequencer: layer sequencer driving the config DMA and the one-layer controller
module network_sequencer #(
    parameter int LAYER_W       = 4,
    parameter int PER_LAYER_CFG = 1,
    parameter int WDOG_W        = 16,
    parameter int WDOG_EN       = 1
) (
    input  logic               clk,
    input  logic               resetState,
    input  logic               start,
    input  logic [LAYER_W-1:0] layersNumber,
    input  logic               dmaFinish,
    input  logic               oneLayerFinish,
    input  logic               abort,
    output logic               loadConfig,
    output logic [LAYER_W-1:0] configLayer,
    output logic               startOneLayer,
    output logic [LAYER_W-1:0] currentLayer,
    output logic               busy,
    output logic               finish,
    output logic               error
);
    typedef enum logic [2:0] {IDLE, LOAD, START, RUN, DONE, ERROR} state_t;

    state_t             state_d, state_q, start_d;
    logic [LAYER_W-1:0] n_q, cur_q;
    logic [WDOG_W-1:0]  wdog_q;
    logic               load_q, kick_q, finish_q, error_q;
    logic               timeout, last, accept;

    assign timeout = (WDOG_EN != 0) && (&wdog_q);
    assign last    = cur_q == n_q - 1'b1;
    assign accept  = start && (state_q == IDLE || (state_q == ERROR && !abort));
    assign start_d = (layersNumber != '0) ? LOAD : DONE;

    assign loadConfig    = load_q;
    assign configLayer   = cur_q;
    assign startOneLayer = kick_q;
    assign currentLayer  = cur_q;
    assign busy          = state_q != IDLE && state_q != ERROR;
    assign finish        = finish_q;
    assign error         = error_q;

    // next state: abort beats any event, and an event on the terminal watchdog count beats the timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? start_d : IDLE;
            LOAD:    state_d = abort ? IDLE : dmaFinish ? START : timeout ? ERROR : LOAD;
            START:   state_d = abort ? IDLE : RUN;
            RUN:     state_d = abort ? IDLE : !oneLayerFinish ? (timeout ? ERROR : RUN) :
                               last ? DONE : (PER_LAYER_CFG != 0) ? LOAD : START;
            DONE:    state_d = IDLE;
            ERROR:   state_d = abort ? IDLE : start ? start_d : ERROR;
            default: state_d = IDLE;
        endcase
    end

    // state, layer bookkeeping, watchdog and pulse outputs registered from the next state
    always_ff @(posedge clk) begin
        if (resetState) begin
            state_q  <= IDLE;
            n_q      <= '0;
            cur_q    <= '0;
            wdog_q   <= '0;
            load_q   <= 1'b0;
            kick_q   <= 1'b0;
            finish_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wdog_q   <= (state_d == state_q && (state_q == LOAD || state_q == RUN)) ? wdog_q + 1'b1 : '0;
            load_q   <= state_d == LOAD && state_q != LOAD;
            kick_q   <= state_d == START;
            finish_q <= state_d == DONE;
            error_q  <= state_d == ERROR;
            if (accept) begin
                n_q   <= layersNumber;
                cur_q <= '0;
            end else if (abort && busy) begin
                cur_q <= '0;
            end else if (state_q == RUN && oneLayerFinish && !last) begin
                cur_q <= cur_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_network_sequencer.sv
// tb_network_sequencer: job-level checks of the sequencer acting as host, DMA and layer controller
module tb_network_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] start = '0, dma = '0, olf = '0, abrt = '0;
    logic [3:0] lay [2];
    logic [1:0] load, kick, busy, fin, err;
    logic [3:0] cfg [2], cur [2];
    int         n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    network_sequencer #(.LAYER_W(4), .PER_LAYER_CFG(1), .WDOG_W(4), .WDOG_EN(1)) u0 (
        .clk(clk), .resetState(rst), .start(start[0]), .layersNumber(lay[0]),
        .dmaFinish(dma[0]), .oneLayerFinish(olf[0]), .abort(abrt[0]),
        .loadConfig(load[0]), .configLayer(cfg[0]), .startOneLayer(kick[0]),
        .currentLayer(cur[0]), .busy(busy[0]), .finish(fin[0]), .error(err[0]));

    network_sequencer #(.LAYER_W(4), .PER_LAYER_CFG(0), .WDOG_W(4), .WDOG_EN(1)) u1 (
        .clk(clk), .resetState(rst), .start(start[1]), .layersNumber(lay[1]),
        .dmaFinish(dma[1]), .oneLayerFinish(olf[1]), .abort(abrt[1]),
        .loadConfig(load[1]), .configLayer(cfg[1]), .startOneLayer(kick[1]),
        .currentLayer(cur[1]), .busy(busy[1]), .finish(fin[1]), .error(err[1]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, int obs, int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle_chk(int d, string tag);
        chk({tag, "_busy"}, busy[d], 0);
        chk({tag, "_load"}, load[d], 0);
        chk({tag, "_kick"}, kick[d], 0);
        chk({tag, "_fin"}, fin[d], 0);
        chk({tag, "_err"}, err[d], 0);
        chk({tag, "_cur"}, cur[d], 0);
    endtask

    // one job on DUT d; dd/ld are DMA and layer response delays (-1 random); mode 1 aborts, mode 2 resets at layer 'at'
    task automatic run_job(int d, int n, int dd, int ld, int mode, int at);
        int per, w;
        per = (d == 0);
        lay[d] = 4'(n);
        start[d] = 1'b1;
        tick();
        start[d] = 1'b0;
        lay[d] = 4'($urandom);
        chk("err_clear", err[d], 0);
        if (n == 0) begin
            chk("zero_fin", fin[d], 1);
            chk("zero_busy", busy[d], 1);
            chk("zero_load", load[d], 0);
            chk("zero_kick", kick[d], 0);
            tick();
            chk("zero_fin_end", fin[d], 0);
            chk("zero_busy_end", busy[d], 0);
            return;
        end
        for (int l = 0; l < n; l++) begin
            if (per != 0 || l == 0) begin
                chk("load", load[d], 1);
                chk("cfg_layer", cfg[d], l);
                chk("load_busy", busy[d], 1);
                w = dd < 0 ? int'($urandom_range(0, 6)) : dd;
                repeat (w) begin
                    olf[d] = 1'($urandom);
                    start[d] = 1'($urandom);
                    tick();
                    chk("load_once", load[d], 0);
                    chk("load_wait_busy", busy[d], 1);
                    chk("kick_early", kick[d], 0);
                end
                olf[d] = 1'b0;
                start[d] = 1'b0;
                dma[d] = 1'b1;
                tick();
                dma[d] = 1'b0;
            end else begin
                chk("no_reload", load[d], 0);
            end
            chk("kick", kick[d], 1);
            chk("kick_cur", cur[d], l);
            tick();
            chk("kick_once", kick[d], 0);
            w = ld < 0 ? int'($urandom_range(0, 6)) : ld;
            repeat (w) begin
                dma[d] = 1'($urandom);
                start[d] = 1'($urandom);
                tick();
                chk("run_busy", busy[d], 1);
                chk("run_fin", fin[d], 0);
                chk("run_cur", cur[d], l);
                chk("run_load", load[d], 0);
            end
            dma[d] = 1'b0;
            start[d] = 1'b0;
            if (mode == 1 && l == at) begin
                abrt[d] = 1'b1;
                olf[d] = 1'b1;
                tick();
                abrt[d] = 1'b0;
                olf[d] = 1'b0;
                idle_chk(d, "abort");
                repeat (4) tick();
                idle_chk(d, "abort_after");
                return;
            end
            if (mode == 2 && l == at) begin
                rst = 1'b1;
                olf[d] = 1'b1;
                tick();
                rst = 1'b0;
                olf[d] = 1'b0;
                idle_chk(0, "mid_reset0");
                idle_chk(1, "mid_reset1");
                return;
            end
            olf[d] = 1'b1;
            tick();
            olf[d] = 1'b0;
        end
        chk("fin", fin[d], 1);
        chk("fin_busy", busy[d], 1);
        chk("fin_cur", cur[d], n - 1);
        chk("fin_load", load[d], 0);
        tick();
        chk("fin_once", fin[d], 0);
        chk("end_busy", busy[d], 0);
        chk("hold_cur", cur[d], n - 1);
    endtask

    initial begin
        lay[0] = '0;
        lay[1] = '0;
        repeat (3) tick();
        idle_chk(0, "reset0");
        idle_chk(1, "reset1");
        rst = 1'b0;
        abrt = 2'b11;
        tick();
        abrt = 2'b00;
        idle_chk(0, "abort_idle");
        run_job(0, 3, 2, 4, 0, 0);
        run_job(1, 4, 2, 4, 0, 0);
        run_job(0, 0, 0, 0, 0, 0);
        run_job(1, 0, 0, 0, 0, 0);
        lay[0] = 4'd2;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        chk("wd_load", load[0], 1);
        for (int i = 1; i < 16; i++) begin
            tick();
            chk("wd_pending", err[0], 0);
            chk("wd_busy", busy[0], 1);
        end
        tick();
        chk("wd_err", err[0], 1);
        chk("wd_err_busy", busy[0], 0);
        dma[0] = 1'b1;
        olf[0] = 1'b1;
        repeat (3) begin
            tick();
            chk("wd_sticky", err[0], 1);
        end
        dma[0] = 1'b0;
        olf[0] = 1'b0;
        run_job(0, 1, -1, -1, 0, 0);
        lay[1] = 4'd1;
        start[1] = 1'b1;
        tick();
        start[1] = 1'b0;
        dma[1] = 1'b1;
        tick();
        dma[1] = 1'b0;
        tick();
        for (int i = 1; i < 16; i++) begin
            tick();
            chk("wd_run_pending", err[1], 0);
        end
        tick();
        chk("wd_run_err", err[1], 1);
        abrt[1] = 1'b1;
        tick();
        abrt[1] = 1'b0;
        idle_chk(1, "err_abort");
        run_job(1, 2, 15, 15, 0, 0);
        run_job(0, 2, 15, 15, 0, 0);
        run_job(0, 3, -1, -1, 1, 1);
        run_job(0, 3, -1, -1, 2, 2);
        run_job(0, 1, -1, -1, 0, 0);
        run_job(0, 15, 0, 0, 0, 0);
        run_job(1, 15, -1, -1, 0, 0);
        repeat (12) run_job(int'($urandom_range(0, 1)), int'($urandom_range(0, 5)), -1, -1, 0, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
